// File: rtl/native_dram_arb_pkg.sv
// Shared types and helpers for native_dram_arbiter.
package native_dram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMD   = 2'd1,
      WDATA = 2'd2
   } arb_state_t;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   // Round-robin pick over up to 8 requesters, starting at last+1 and wrapping.
   // Unused upper request bits must be zero; returns last when nothing requests.
   function automatic logic [2:0] rr_next(input logic [7:0] req, input logic [2:0] last);
      logic [2:0] idx;
      rr_next = last;
      for (int unsigned k = 8; k >= 1; k--) begin
         idx = last + 3'(k);
         if (req[idx]) rr_next = idx;
      end
   endfunction

endpackage

// File: rtl/native_dram_arb_id_fifo.sv
// Synchronous FIFO holding the port ID of each outstanding read.
module native_dram_arb_id_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           din_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/native_dram_arbiter.sv
// Round-robin arbiter sharing one MIG-style native DRAM port between DMA masters.
// Optional NATIVE_DRAM_ARB_STATS_EN adds per-port accepted-command counters (stat_grants).
module native_dram_arbiter
   import native_dram_arb_pkg::*;
#(
   parameter int unsigned NUM_PORTS     = 4,
   parameter int unsigned DRAM_AWIDTH   = 32,
   parameter int unsigned DRAM_DWIDTH   = 512,
   parameter int unsigned RD_FIFO_DEPTH = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 init_calib_complete,
   input  logic [NUM_PORTS-1:0]                 req_en,
   input  logic [3*NUM_PORTS-1:0]               req_cmd,
   input  logic [DRAM_AWIDTH*NUM_PORTS-1:0]     req_addr,
   output logic [NUM_PORTS-1:0]                 req_rdy,
   input  logic [NUM_PORTS-1:0]                 req_wdf_wren,
   input  logic [NUM_PORTS-1:0]                 req_wdf_end,
   input  logic [DRAM_DWIDTH*NUM_PORTS-1:0]     req_wdf_data,
   input  logic [DRAM_DWIDTH/8*NUM_PORTS-1:0]   req_wdf_mask,
   output logic [NUM_PORTS-1:0]                 req_wdf_rdy,
   output logic [DRAM_DWIDTH-1:0]               req_rd_data,
   output logic [NUM_PORTS-1:0]                 req_rd_valid,
   output logic                                 dram_en,
   output logic [2:0]                           dram_cmd,
   output logic [DRAM_AWIDTH-1:0]               dram_addr,
   input  logic                                 dram_rdy,
   output logic                                 dram_wdf_wren,
   output logic                                 dram_wdf_end,
   output logic [DRAM_DWIDTH-1:0]               dram_wdf_data,
   output logic [DRAM_DWIDTH/8-1:0]             dram_wdf_mask,
   input  logic                                 dram_wdf_rdy,
   input  logic [DRAM_DWIDTH-1:0]               dram_rd_data,
   input  logic                                 dram_rd_data_valid,
   output logic                                 err_underflow
`ifdef NATIVE_DRAM_ARB_STATS_EN
   ,
   output logic [32*NUM_PORTS-1:0]              stat_grants
`endif
);
   localparam int unsigned GW = $clog2(NUM_PORTS);
   localparam int unsigned MW = DRAM_DWIDTH / 8;

   arb_state_t      state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   last_q, last_d;
   logic            wdf_done_q, wdf_done_d;
   logic            err_q;

   logic [NUM_PORTS-1:0]   elig;
   logic [7:0]             elig8;
   logic [2:0]             rr_idx;
   logic                   g_en, g_wren, g_end, wdf_last;
   logic [2:0]             g_cmd;
   logic [DRAM_AWIDTH-1:0] g_addr;
   logic [DRAM_DWIDTH-1:0] g_data;
   logic [MW-1:0]          g_mask;

   logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [GW-1:0]          fifo_head;
   logic [$clog2(RD_FIFO_DEPTH):0] fifo_count;

   assign g_en     = req_en[grant_q];
   assign g_cmd    = req_cmd[grant_q*3 +: 3];
   assign g_addr   = req_addr[grant_q*DRAM_AWIDTH +: DRAM_AWIDTH];
   assign g_wren   = req_wdf_wren[grant_q];
   assign g_end    = req_wdf_end[grant_q];
   assign g_data   = req_wdf_data[grant_q*DRAM_DWIDTH +: DRAM_DWIDTH];
   assign g_mask   = req_wdf_mask[grant_q*MW +: MW];
   assign wdf_last = g_wren & dram_wdf_rdy & g_end;

   // A read may only win arbitration while the ID FIFO has room.
   always_comb begin
      elig = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++)
         elig[i] = req_en[i] & (~req_cmd[3*i] | ~fifo_full);
      elig8 = '0;
      elig8[NUM_PORTS-1:0] = elig;
      rr_idx = rr_next(elig8, 3'(last_q));
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_d        = last_q;
      wdf_done_d    = wdf_done_q;
      fifo_push     = 1'b0;
      dram_en       = 1'b0;
      dram_cmd      = '0;
      dram_addr     = '0;
      dram_wdf_wren = 1'b0;
      dram_wdf_end  = 1'b0;
      dram_wdf_data = '0;
      dram_wdf_mask = '0;
      req_rdy       = '0;
      req_wdf_rdy   = '0;
      case (state_q)
         IDLE: begin
            wdf_done_d = 1'b0;
            if (init_calib_complete && (|elig)) begin
               grant_d = rr_idx[GW-1:0];
               last_d  = rr_idx[GW-1:0];
               state_d = CMD;
            end
         end
         CMD: begin
            dram_en              = g_en;
            dram_cmd             = g_cmd;
            dram_addr            = g_addr;
            req_rdy[grant_q]     = dram_rdy;
            dram_wdf_wren        = g_wren;
            dram_wdf_end         = g_end;
            dram_wdf_data        = g_data;
            dram_wdf_mask        = g_mask;
            req_wdf_rdy[grant_q] = dram_wdf_rdy;
            // Write data may complete before the command is taken; wdf_done remembers it.
            if (g_en && dram_rdy) begin
               if (g_cmd[0] == CMD_READ[0]) begin
                  fifo_push = 1'b1;
                  state_d   = IDLE;
               end else if (wdf_done_q || wdf_last) begin
                  state_d = IDLE;
               end else begin
                  state_d = WDATA;
               end
            end else if (wdf_last) begin
               wdf_done_d = 1'b1;
            end
         end
         WDATA: begin
            dram_wdf_wren        = g_wren;
            dram_wdf_end         = g_end;
            dram_wdf_data        = g_data;
            dram_wdf_mask        = g_mask;
            req_wdf_rdy[grant_q] = dram_wdf_rdy;
            if (wdf_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         last_q     <= GW'(NUM_PORTS - 1);
         wdf_done_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         wdf_done_q <= wdf_done_d;
         err_q      <= err_q | (dram_rd_data_valid & fifo_empty);
      end
   end

   assign fifo_pop      = dram_rd_data_valid & ~fifo_empty;
   assign req_rd_data   = dram_rd_data;
   assign err_underflow = err_q;

   always_comb begin
      req_rd_valid = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++)
         req_rd_valid[i] = fifo_pop & (fifo_head == GW'(i));
   end

   native_dram_arb_id_fifo #(
      .DEPTH (RD_FIFO_DEPTH),
      .WIDTH (GW)
   ) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .din_i   (grant_q),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

`ifdef NATIVE_DRAM_ARB_STATS_EN
   logic [31:0] stat_q [NUM_PORTS];
   logic        cmd_acc;

   assign cmd_acc = (state_q == CMD) & g_en & dram_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) stat_q[i] <= '0;
      end else if (cmd_acc) begin
         stat_q[grant_q] <= stat_q[grant_q] + 32'd1;
      end
   end

   always_comb begin
      stat_grants = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++)
         stat_grants[32*i +: 32] = stat_q[i];
   end
`endif

endmodule
